// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - mode encodings shared by the shift register and its bench
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'b00,
        SHIFT_UP   = 2'b01,
        SHIFT_DOWN = 2'b10,
        LOAD       = 2'b11
    } mode_e;

endpackage

// File: rtl/univ_shift_reg_shift_cell.sv
// rtl/univ_shift_reg_shift_cell.sv - one register stage: 4:1 next-state mux into a set/reset/enable flop
module shift_cell
    import univ_shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       up_src,
    input  logic       down_src,
    input  logic       p_bit,
    output logic       q
);

    logic d;

    always_comb begin
        d = q;
        case (mode)
            HOLD:       d = q;
            SHIFT_UP:   d = up_src;
            SHIFT_DOWN: d = down_src;
            LOAD:       d = p_bit;
            default:    d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            q <= 1'b0;
        else if (set)
            q <= 1'b1;
        else if (enable)
            q <= d;
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with serial word counter and word-ready pulse
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic                       s_in_lsb,
    input  logic                       s_in_msb,
    input  logic [WIDTH-1:0]           p_in,
    output logic [WIDTH-1:0]           p_out,
    output logic                       s_out_msb,
    output logic                       s_out_lsb,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       word_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    // Neighbour chains with the serial inputs spliced onto the ends, so every
    // cell takes its up/down source by a plain in-range index.
    logic [WIDTH:0] up_chain;
    logic [WIDTH:0] down_chain;

    assign up_chain   = {p_out, s_in_lsb};
    assign down_chain = {s_in_msb, p_out};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_cell u_cell (
            .clk      (clk),
            .reset    (reset),
            .set      (set),
            .enable   (enable),
            .mode     (mode),
            .up_src   (up_chain[i]),
            .down_src (down_chain[i+1]),
            .p_bit    (p_in[i]),
            .q        (p_out[i])
        );
    end

    assign s_out_msb = p_out[WIDTH-1];
    assign s_out_lsb = p_out[0];

    logic is_shift;
    assign is_shift = (mode == SHIFT_UP) || (mode == SHIFT_DOWN);

    always_ff @(posedge clk) begin
        if (reset || set) begin
            bit_count  <= '0;
            word_valid <= 1'b0;
        end else if (enable && is_shift) begin
            if (bit_count == CW'(WIDTH - 1)) begin
                bit_count  <= '0;
                word_valid <= 1'b1;
            end else begin
                bit_count  <= bit_count + CW'(1);
                word_valid <= 1'b0;
            end
        end else begin
            if (enable && (mode == LOAD))
                bit_count <= '0;
            word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg at WIDTH=4
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             set;
    logic             enable;
    logic [1:0]       mode;
    logic             s_in_lsb;
    logic             s_in_msb;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] p_out;
    logic             s_out_msb;
    logic             s_out_lsb;
    logic [2:0]       bit_count;
    logic             word_valid;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .set        (set),
        .enable     (enable),
        .mode       (mode),
        .s_in_lsb   (s_in_lsb),
        .s_in_msb   (s_in_msb),
        .p_in       (p_in),
        .p_out      (p_out),
        .s_out_msb  (s_out_msb),
        .s_out_lsb  (s_out_lsb),
        .bit_count  (bit_count),
        .word_valid (word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] p, input logic [2:0] bc, input logic wv);
        check({tag, ".p_out"}, 32'(p_out), 32'(p));
        check({tag, ".bit_count"}, 32'(bit_count), 32'(bc));
        check({tag, ".word_valid"}, 32'(word_valid), 32'(wv));
        check({tag, ".s_out_lsb"}, 32'(s_out_lsb), 32'(p[0]));
        check({tag, ".s_out_msb"}, 32'(s_out_msb), 32'(p[3]));
    endtask

    logic [3:0] up_bits;
    logic [3:0] up_exp [4];
    logic [2:0] up_bc  [4];

    initial begin
        reset = 1'b1; set = 1'b0; enable = 1'b1; mode = SHIFT_UP;
        s_in_lsb = 1'b1; s_in_msb = 1'b1; p_in = 4'hF;
        step();
        expect_state("reset", 4'h0, 3'd0, 1'b0);

        // shift up 1,0,1,1 -> 0001,0010,0101,1011
        reset = 1'b0; mode = SHIFT_UP;
        up_bits = 4'b1101;
        up_exp[0] = 4'h1; up_exp[1] = 4'h2; up_exp[2] = 4'h5; up_exp[3] = 4'hB;
        up_bc[0] = 3'd1;  up_bc[1] = 3'd2;  up_bc[2] = 3'd3;  up_bc[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            s_in_lsb = up_bits[i];
            step();
            expect_state($sformatf("up%0d", i), up_exp[i], up_bc[i], i == 3);
        end
        mode = HOLD;
        step();
        expect_state("hold", 4'hB, 3'd0, 1'b0);

        // load then shift down with zeros
        mode = LOAD; p_in = 4'hA;
        step();
        expect_state("load", 4'hA, 3'd0, 1'b0);
        mode = SHIFT_DOWN; s_in_msb = 1'b0;
        step();
        expect_state("down0", 4'h5, 3'd1, 1'b0);
        step();
        expect_state("down1", 4'h2, 3'd2, 1'b0);

        // enable low freezes everything
        enable = 1'b0; mode = SHIFT_UP; s_in_lsb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state($sformatf("frozen%0d", i), 4'h2, 3'd2, 1'b0);
        end

        // direction change keeps the count
        enable = 1'b1;
        step();
        expect_state("dirchg0", 4'h5, 3'd3, 1'b0);
        s_in_lsb = 1'b0;
        step();
        expect_state("dirchg1", 4'hA, 3'd0, 1'b1);

        // reset beats set; set alone presets and clears count
        reset = 1'b1; set = 1'b1;
        step();
        expect_state("rst_set", 4'h0, 3'd0, 1'b0);
        reset = 1'b0;
        step();
        expect_state("set", 4'hF, 3'd0, 1'b0);
        set = 1'b0; s_in_lsb = 1'b0;
        step();
        expect_state("set_shift", 4'hE, 3'd1, 1'b0);
        set = 1'b1;
        step();
        expect_state("set_mid", 4'hF, 3'd0, 1'b0);
        set = 1'b0;

        // reset mid-word discards progress
        s_in_lsb = 1'b1;
        step();
        step();
        expect_state("pre_rst", 4'hF, 3'd2, 1'b0);
        reset = 1'b1;
        step();
        expect_state("mid_rst", 4'h0, 3'd0, 1'b0);
        reset = 1'b0;
        step(); expect_state("post_rst0", 4'h1, 3'd1, 1'b0);
        step(); expect_state("post_rst1", 4'h3, 3'd2, 1'b0);
        step(); expect_state("post_rst2", 4'h7, 3'd3, 1'b0);
        step(); expect_state("post_rst3", 4'hF, 3'd0, 1'b1);

        // load mid-word restarts the count
        s_in_lsb = 1'b0;
        step(); expect_state("pre_ld0", 4'hE, 3'd1, 1'b0);
        step(); expect_state("pre_ld1", 4'hC, 3'd2, 1'b0);
        mode = LOAD; p_in = 4'h6;
        step(); expect_state("mid_ld", 4'h6, 3'd0, 1'b0);
        mode = SHIFT_UP; s_in_lsb = 1'b1;
        step(); expect_state("post_ld0", 4'hD, 3'd1, 1'b0);
        step(); expect_state("post_ld1", 4'hB, 3'd2, 1'b0);
        step(); expect_state("post_ld2", 4'h7, 3'd3, 1'b0);
        s_in_lsb = 1'b0;
        step(); expect_state("post_ld3", 4'hE, 3'd0, 1'b1);
        mode = HOLD;
        step(); expect_state("final_hold", 4'hE, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the register length in bits (legal range 2 to 32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port set, input, 1 bit: synchronous preset of the register to all ones.
REQ-005 The block SHALL have port enable, input, 1 bit: clock enable for mode operations.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift up, 10 shift down, 11 parallel load.
REQ-007 The block SHALL have port s_in_lsb, input, 1 bit: serial data entering bit 0 on shift up.
REQ-008 The block SHALL have port s_in_msb, input, 1 bit: serial data entering bit WIDTH-1 on shift down.
REQ-009 The block SHALL have port p_in, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port p_out, output, WIDTH bits: register contents.
REQ-011 The block SHALL have ports s_out_msb and s_out_lsb, outputs, 1 bit each, equal to p_out[WIDTH-1] and p_out[0].
REQ-012 The block SHALL have port bit_count, output, clog2(WIDTH+1) bits: serial bits shifted into the current word.
REQ-013 The block SHALL have port word_valid, output, 1 bit: one-cycle pulse when a full serial word is assembled.

Function
REQ-014 Update priority SHALL be: reset, then set, then enable with mode; with enable low, p_out and bit_count hold.
REQ-015 Shift up SHALL load p_out[0] from s_in_lsb and p_out[i] from p_out[i-1] for i = 1 to WIDTH-1.
REQ-016 Shift down SHALL load p_out[WIDTH-1] from s_in_msb and p_out[i] from p_out[i+1] for i = 0 to WIDTH-2.
REQ-017 Parallel load SHALL copy p_in into p_out and clear bit_count to 0.
REQ-018 Each enabled shift (up or down) SHALL increment bit_count; a shift with bit_count = WIDTH-1 SHALL wrap it to 0.
REQ-019 word_valid SHALL be registered and asserted for exactly the one cycle after the shift that wraps bit_count, when p_out holds the complete word.
REQ-020 A direction change mid-word SHALL NOT clear bit_count.
REQ-021 set SHALL clear bit_count and SHALL NOT assert word_valid.
REQ-022 Hold (mode 00) SHALL keep p_out and bit_count unchanged.
REQ-023 s_out_msb and s_out_lsb SHALL be combinational copies of register bits with no added latency.

Reset
REQ-024 With reset high at a clk edge, p_out SHALL become 0, bit_count 0, and word_valid 0, regardless of set, enable and mode.
REQ-025 Reset mid-word SHALL discard partial progress; a full WIDTH further shifts SHALL be required before the next word_valid.

Structure
REQ-026 The mode encodings (HOLD, SHIFT_UP, SHIFT_DOWN, LOAD) SHALL be constants in a shared package used by the design and the bench.
REQ-027 Each stage SHALL be an instance of the sub-module shift_cell (4:1 next-state mux feeding the codebase D flip-flop with set/reset/enable), replicated WIDTH times by a generate loop.
REQ-028 bit_count and word_valid SHALL be implemented as separate control logic in univ_shift_reg.

Verification
REQ-029 WIDTH=4, reset, mode=01, s_in_lsb = 1,0,1,1 on four cycles -> p_out = 0001, 0010, 0101, 1011; bit_count = 1,2,3,0; word_valid high only in the cycle after the fourth shift.
REQ-030 Load p_in=1010, then mode=10 with s_in_msb=0 for two cycles -> p_out = 0101, then 0010; s_out_lsb = 0, 1, 0.
REQ-031 Mid-word with enable=0 for 3 cycles, mode=01 -> p_out and bit_count frozen, no word_valid.
REQ-032 set=1 and reset=1 together -> p_out=0000; set alone -> p_out=1111, bit_count=0.
REQ-033 Two shifts, then reset, then four shifts -> word_valid only after the fourth post-reset shift.
REQ-034 Two shifts, then load 0110, then three shifts -> no word_valid; a fourth shift -> word_valid.
